// File: rtl/nios2_debug_mon_mem_pkg.sv
// Shared definitions for the debug-monitor memory engine:
// jdo field positions and the engine state encoding.
package nios2_debug_mon_pkg;

    localparam int ADDR_LSB    = 17;
    localparam int RD_FLAG_BIT = 34;
    localparam int ERR_CLR_BIT = 36;
    localparam int WDATA_MSB   = 34;
    localparam int WDATA_LSB   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR,
        ST_CPU_RD
    } mon_state_e;

endpackage

// File: rtl/nios2_debug_mon_mem_if.sv
// JTAG-wrapper and CPU-slave signal bundle of the monitor engine.
// The engine uses the slave modport; the wrapper/CPU side uses master.
interface nios2_debug_mon_mem_if #(
    parameter int AW = 8
);
    logic [37:0]   jdo;
    logic          take_action_ocimem_a;
    logic          take_action_ocimem_b;
    logic          take_no_action_ocimem_a;
    logic [31:0]   MonDReg;
    logic          monitor_ready;
    logic          monitor_error;
    logic [AW-1:0] cpu_address;
    logic          cpu_read;
    logic          cpu_write;
    logic [31:0]   cpu_writedata;
    logic [31:0]   cpu_readdata;
    logic          cpu_waitrequest;

    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b,
        output take_no_action_ocimem_a,
        output cpu_address, cpu_read, cpu_write, cpu_writedata,
        input  MonDReg, monitor_ready, monitor_error,
        input  cpu_readdata, cpu_waitrequest
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b,
        input  take_no_action_ocimem_a,
        input  cpu_address, cpu_read, cpu_write, cpu_writedata,
        output MonDReg, monitor_ready, monitor_error,
        output cpu_readdata, cpu_waitrequest
    );
endinterface

// File: rtl/nios2_debug_mon_mem_ram.sv
// Single-port synchronous monitor RAM, 2^AW x 32,
// with RD_LAT registered read stages.
module nios2_debug_mon_ram #(
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q  [2**AW];
    logic [31:0] pipe_q [RD_LAT];

    // No reset: RAM contents survive reset_n
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        pipe_q[0] <= mem_q[addr_i];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rdata_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/nios2_debug_mon_mem.sv
// Debug-monitor memory engine: JTAG-driven word access to the
// monitor RAM, with a CPU slave port served only when idle.
module nios2_debug_mon_mem
    import nios2_debug_mon_pkg::*;
#(
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input logic                  clk,
    input logic                  reset_n,
    nios2_debug_mon_mem_if.slave bus
);

    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    mon_state_e    state_q, state_d;
    logic [AW-1:0] mon_a_q, mon_a_d;
    logic [31:0]   mon_d_q, mon_d_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          cpu_wait;
    logic [31:0]   cpu_rd_out;

    logic          stb_a, stb_b, stb_n, stb_any;
    logic [AW-1:0] j_addr;
    logic          j_rd, j_clr;
    logic [31:0]   j_wdata;
    logic          lat_done;
    logic          unused_jdo;

    assign stb_a    = bus.take_action_ocimem_a;
    assign stb_b    = bus.take_action_ocimem_b;
    assign stb_n    = bus.take_no_action_ocimem_a;
    assign stb_any  = stb_a | stb_b | stb_n;
    assign j_addr   = bus.jdo[ADDR_LSB +: AW];
    assign j_rd     = bus.jdo[RD_FLAG_BIT];
    assign j_clr    = bus.jdo[ERR_CLR_BIT];
    assign j_wdata  = bus.jdo[WDATA_MSB:WDATA_LSB];
    assign lat_done = (cnt_q == LAT_M1);

    assign unused_jdo = ^{bus.jdo[37], bus.jdo[35], bus.jdo[2:0]};

    always_comb begin
        state_d    = state_q;
        mon_a_d    = mon_a_q;
        mon_d_d    = mon_d_q;
        ready_d    = ready_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        ram_we     = 1'b0;
        ram_addr   = mon_a_q;
        ram_wdata  = mon_d_q;
        cpu_wait   = 1'b1;
        cpu_rd_out = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Strobe priority a > b > no_action; CPU only when none
                if (stb_a) begin
                    mon_a_d = j_addr;
                    if (j_clr) begin
                        err_d = 1'b0;
                    end
                    if (j_rd) begin
                        ram_addr = j_addr;
                        ready_d  = 1'b0;
                        state_d  = ST_RD_WAIT;
                    end
                end else if (stb_b) begin
                    mon_d_d = j_wdata;
                    ready_d = 1'b0;
                    state_d = ST_WR;
                end else if (stb_n) begin
                    ready_d = 1'b0;
                    state_d = ST_RD_WAIT;
                end else if (bus.cpu_write) begin
                    ram_we    = 1'b1;
                    ram_addr  = bus.cpu_address;
                    ram_wdata = bus.cpu_writedata;
                    cpu_wait  = 1'b0;
                    if (bus.cpu_read) begin
                        err_d = 1'b1;
                    end
                end else if (bus.cpu_read) begin
                    ram_addr = bus.cpu_address;
                    state_d  = ST_CPU_RD;
                end
            end
            ST_RD_WAIT: begin
                if (stb_any) begin
                    err_d = 1'b1;
                end
                if (lat_done) begin
                    mon_d_d = ram_rdata;
                    mon_a_d = mon_a_q + AW'(1);
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_WR: begin
                if (stb_any) begin
                    err_d = 1'b1;
                end
                ram_we  = 1'b1;
                mon_a_d = mon_a_q + AW'(1);
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_CPU_RD: begin
                if (stb_any) begin
                    err_d = 1'b1;
                end
                // Data is presented straight from the RAM in the ack cycle
                if (lat_done) begin
                    cpu_wait   = 1'b0;
                    cpu_rd_out = ram_rdata;
                    rdata_d    = ram_rdata;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mon_a_q <= '0;
            mon_d_q <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    nios2_debug_mon_ram #(
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we & reset_n),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign bus.MonDReg         = mon_d_q;
    assign bus.monitor_ready   = ready_q;
    assign bus.monitor_error   = err_q;
    assign bus.cpu_readdata    = cpu_rd_out;
    assign bus.cpu_waitrequest = cpu_wait | ~reset_n;

endmodule

// File: tb/tb_nios2_debug_mon_mem.sv
// Randomized bench for nios2_debug_mon_mem against a
// transaction-level model of the monitor RAM and registers.
module tb_nios2_debug_mon_mem;

    localparam int AW     = 8;
    localparam int RD_LAT = 1;
    localparam int N      = 2**AW;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    nios2_debug_mon_mem_if #(.AW(AW)) bus ();

    nios2_debug_mon_mem #(
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]   m_mem [N];
    logic [AW-1:0] m_a;
    logic [31:0]   m_d;
    logic          m_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] mk_jdo(input logic [AW-1:0] addr,
                                           input logic rd, input logic clr);
        logic [37:0] j;
        j = 38'({$urandom(), $urandom()});
        j[17 +: AW] = addr;
        j[34] = rd;
        j[36] = clr;
        return j;
    endfunction

    function automatic logic [37:0] mk_wjdo(input logic [31:0] wd);
        logic [37:0] j;
        j = 38'({$urandom(), $urandom()});
        j[34:3] = wd;
        return j;
    endfunction

    task automatic clr_strobes();
        bus.take_action_ocimem_a    = 1'b0;
        bus.take_action_ocimem_b    = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe(input int k);
        case (k)
            0: bus.take_action_ocimem_a = 1'b1;
            1: bus.take_action_ocimem_b = 1'b1;
            default: bus.take_no_action_ocimem_a = 1'b1;
        endcase
    endtask

    // One cycle after issue the engine is busy: optionally fire a stray
    // strobe there, which must be dropped and flagged.
    task automatic busy_step(input int lat, input bit inj);
        if (lat == 1) begin
            clr_strobes();
            if (inj) begin
                bus.jdo = mk_jdo(AW'($urandom()), 1'($urandom_range(0, 1)), 1'b1);
                strobe($urandom_range(0, 2));
                m_err = 1'b1;
            end
        end else if (lat == 2) begin
            clr_strobes();
        end
    endtask

    task automatic wait_ready(input string tag, input int exp_lat, input bit inj);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            busy_step(lat, inj);
        end while (!bus.monitor_ready && lat < 20);
        if (lat == 1) begin
            @(negedge clk);
            clr_strobes();
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdy"}, 32'(bus.monitor_ready), 32'd1);
    endtask

    task automatic j_setaddr(input logic [AW-1:0] addr, input logic clr);
        bus.jdo = mk_jdo(addr, 1'b0, clr);
        strobe(0);
        @(negedge clk);
        clr_strobes();
        m_a = addr;
        if (clr) m_err = 1'b0;
        chk("seta_rdy", 32'(bus.monitor_ready), 32'd1);
        chk("seta_err", 32'(bus.monitor_error), 32'(m_err));
    endtask

    task automatic j_read(input logic [AW-1:0] addr, input logic clr, input bit inj);
        bus.jdo = mk_jdo(addr, 1'b1, clr);
        strobe(0);
        if (clr) m_err = 1'b0;
        wait_ready("jrd", RD_LAT + 1, inj);
        m_d = m_mem[addr];
        m_a = addr + AW'(1);
        chk("jrd_data", bus.MonDReg, m_d);
        chk("jrd_err", 32'(bus.monitor_error), 32'(m_err));
    endtask

    task automatic j_next(input bit inj);
        strobe(2);
        wait_ready("jnx", RD_LAT + 1, inj);
        m_d = m_mem[m_a];
        m_a = m_a + AW'(1);
        chk("jnx_data", bus.MonDReg, m_d);
        chk("jnx_err", 32'(bus.monitor_error), 32'(m_err));
    endtask

    task automatic j_write(input logic [31:0] wd, input bit inj);
        bus.jdo = mk_wjdo(wd);
        strobe(1);
        wait_ready("jwr", 2, inj);
        m_mem[m_a] = wd;
        m_d = wd;
        m_a = m_a + AW'(1);
        chk("jwr_data", bus.MonDReg, m_d);
        chk("jwr_err", 32'(bus.monitor_error), 32'(m_err));
    endtask

    task automatic cpu_wr(input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic both);
        bus.cpu_address   = addr;
        bus.cpu_writedata = data;
        bus.cpu_write     = 1'b1;
        bus.cpu_read      = both;
        #1;
        chk("cwr_wait", 32'(bus.cpu_waitrequest), 32'd0);
        @(negedge clk);
        bus.cpu_write = 1'b0;
        bus.cpu_read  = 1'b0;
        m_mem[addr] = data;
        if (both) m_err = 1'b1;
        chk("cwr_err", 32'(bus.monitor_error), 32'(m_err));
    endtask

    task automatic cpu_rd(input logic [AW-1:0] addr, input bit inj);
        int lat;
        logic [31:0] got;
        lat = 0;
        bus.cpu_address = addr;
        bus.cpu_read    = 1'b1;
        #1;
        while (bus.cpu_waitrequest && lat < 20) begin
            @(negedge clk);
            lat++;
            busy_step(lat, inj);
            #1;
        end
        got = bus.cpu_readdata;
        chk("crd_lat", 32'(lat), 32'(RD_LAT));
        chk("crd_data", got, m_mem[addr]);
        @(negedge clk);
        bus.cpu_read = 1'b0;
        clr_strobes();
        chk("crd_err", 32'(bus.monitor_error), 32'(m_err));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mond"}, bus.MonDReg, 32'd0);
        chk({tag, "_rdy"}, 32'(bus.monitor_ready), 32'd1);
        chk({tag, "_err"}, 32'(bus.monitor_error), 32'd0);
        chk({tag, "_wait"}, 32'(bus.cpu_waitrequest), 32'd1);
        chk({tag, "_crd"}, bus.cpu_readdata, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] wd;
        bit inj;

        bus.jdo           = '0;
        bus.cpu_address   = '0;
        bus.cpu_read      = 1'b0;
        bus.cpu_write     = 1'b0;
        bus.cpu_writedata = '0;
        clr_strobes();
        m_a   = '0;
        m_d   = '0;
        m_err = 1'b0;

        repeat (2) @(negedge clk);
        chk_reset_vals("rst0");
        reset_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            cpu_wr(AW'(i), $urandom(), 1'b0);
        end

        // Read at 0x10 then read-next proves MonAReg advanced to 0x11
        cpu_wr(8'h10, 32'hDEADBEEF, 1'b0);
        j_read(8'h10, 1'b0, 1'b0);
        chk("dir_beef", bus.MonDReg, 32'hDEADBEEF);
        j_next(1'b0);

        // Address wrap 0xFF -> 0x00
        j_setaddr(8'hFF, 1'b0);
        j_write(32'h12345678, 1'b0);
        j_write(32'hCAFEF00D, 1'b0);
        j_read(8'hFF, 1'b0, 1'b0);
        chk("wrap_ff", bus.MonDReg, 32'h12345678);
        j_read(8'h00, 1'b0, 1'b0);
        chk("wrap_00", bus.MonDReg, 32'hCAFEF00D);

        // Sticky error and its clear
        j_next(1'b1);
        chk("err_set", 32'(bus.monitor_error), 32'd1);
        j_write($urandom(), 1'b0);
        cpu_rd(8'h07, 1'b0);
        chk("err_sticky", 32'(bus.monitor_error), 32'd1);
        j_setaddr(8'h40, 1'b1);
        chk("err_clr", 32'(bus.monitor_error), 32'd0);

        // JTAG write and CPU read in the same cycle: JTAG goes first
        j_setaddr(8'h05, 1'b0);
        wd = $urandom();
        bus.jdo = mk_wjdo(wd);
        strobe(1);
        bus.cpu_address = 8'h05;
        bus.cpu_read    = 1'b1;
        lat = 0;
        #1;
        chk("cont_wait0", 32'(bus.cpu_waitrequest), 32'd1);
        while (bus.cpu_waitrequest && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) clr_strobes();
            #1;
        end
        m_mem[m_a] = wd;
        m_d = wd;
        m_a = m_a + AW'(1);
        chk("cont_lat", 32'(lat), 32'(RD_LAT + 2));
        chk("cont_data", bus.cpu_readdata, wd);
        @(negedge clk);
        bus.cpu_read = 1'b0;
        chk("cont_mond", bus.MonDReg, m_d);

        // CPU write then JTAG read of the same word
        cpu_wr(8'h20, 32'hA5A5A5A5, 1'b0);
        j_read(8'h20, 1'b0, 1'b0);
        chk("cw_jr", bus.MonDReg, 32'hA5A5A5A5);

        // Read+write together is a write plus an error
        cpu_wr(8'h21, 32'h0BAD0BAD, 1'b1);
        cpu_rd(8'h21, 1'b0);

        // Reset pulse while in WR
        j_setaddr(8'h33, 1'b0);
        bus.jdo = mk_wjdo($urandom());
        strobe(1);
        @(negedge clk);
        clr_strobes();
        chk("pre_rst_rdy", 32'(bus.monitor_ready), 32'd0);
        #1 reset_n = 1'b0;
        #1 chk_reset_vals("rst1");
        @(negedge clk);
        reset_n = 1'b1;
        m_a = '0;
        m_d = '0;
        m_err = 1'b0;
        cpu_wr(8'h33, m_mem[8'h33], 1'b0);
        chk("post_rst_rdy", 32'(bus.monitor_ready), 32'd1);
        j_next(1'b0);

        repeat (400) begin
            inj = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 6))
                0: j_setaddr(AW'($urandom()), 1'($urandom_range(0, 1)));
                1: j_read(AW'($urandom()), 1'($urandom_range(0, 1)), inj);
                2: j_next(inj);
                3: j_write($urandom(), inj);
                4: cpu_wr(AW'($urandom()), $urandom(), ($urandom_range(0, 7) == 0));
                5: cpu_rd(AW'($urandom()), inj);
                default: @(negedge clk);
            endcase
        end

        for (int i = 0; i < 8; i++) begin
            cpu_rd(AW'(N - 4 + i), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
